id_stage: RTL and testbench

- Instruction-decode stage of the RV32I core.
- Decodes the fetched instruction and reads the 32x32 register file.
- Drives the ALU control code, operand-select, immediate and operand registers consumed by the EX stage through a registered ID/EX pipeline boundary.
- Accepts the write-back port, detects load-use hazards, and honours downstream stall and branch flush.

---
 rtl/id_stage_if.sv | 47 ++++
 rtl/id_stage.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// IF/ID/EX/WB-facing bus of the RV32I decode stage: instruction handshake,
// stall/flush controls, write-back port and the registered ID/EX payload.
interface id_stage_if #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
);
   logic                      i_instr_valid;
   logic [31:0]               i_instr;
   logic [DATA_WIDTH-1:0]     i_PC;
   logic                      o_instr_ready;
   logic                      i_stall;
   logic                      i_flush;
   logic                      i_wb_en;
   logic [REG_ADDR_WIDTH-1:0] i_wb_addr;
   logic [DATA_WIDTH-1:0]     i_wb_data;
   logic                      o_valid;
   logic [DATA_WIDTH-1:0]     o_PC;
   logic [DATA_WIDTH-1:0]     o_register1;
   logic [DATA_WIDTH-1:0]     o_register2;
   logic [DATA_WIDTH-1:0]     o_constante;
   logic                      o_ALUSrc;
   logic [2:0]                o_ALUControl;
   logic [REG_ADDR_WIDTH-1:0] o_rd;
   logic                      o_RegWrite;
   logic                      o_MemRead;
   logic                      o_MemWrite;
   logic [1:0]                o_Branch;
   logic                      o_illegal;

   // Decode stage side
   modport slave (
      input  i_instr_valid, i_instr, i_PC, i_stall, i_flush,
             i_wb_en, i_wb_addr, i_wb_data,
      output o_instr_ready, o_valid, o_PC, o_register1, o_register2,
             o_constante, o_ALUSrc, o_ALUControl, o_rd, o_RegWrite,
             o_MemRead, o_MemWrite, o_Branch, o_illegal
   );

   // Surrounding pipeline side
   modport master (
      output i_instr_valid, i_instr, i_PC, i_stall, i_flush,
             i_wb_en, i_wb_addr, i_wb_data,
      input  o_instr_ready, o_valid, o_PC, o_register1, o_register2,
             o_constante, o_ALUSrc, o_ALUControl, o_rd, o_RegWrite,
             o_MemRead, o_MemWrite, o_Branch, o_illegal
   );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, 32x32 register file, load-use hazard
// detection and registered ID/EX boundary. Define ID_BYPASS_EN to forward WB data.
module id_stage #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input logic        i_clk,
   input logic        i_rst,
   id_stage_if.slave  id_bus
);
   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b011;
   localparam logic [2:0] ALU_SRA = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_BLT  = 2'b11;

   // Instruction fields
   logic [31:0]               w_instr;
   logic [6:0]                w_opcode;
   logic [2:0]                w_funct3;
   logic [6:0]                w_funct7;
   logic [REG_ADDR_WIDTH-1:0] w_rd;
   logic [REG_ADDR_WIDTH-1:0] w_rs1;
   logic [REG_ADDR_WIDTH-1:0] w_rs2;

   assign w_instr  = id_bus.i_instr;
   assign w_opcode = w_instr[6:0];
   assign w_funct3 = w_instr[14:12];
   assign w_funct7 = w_instr[31:25];
   assign w_rd     = REG_ADDR_WIDTH'(w_instr[11:7]);
   assign w_rs1    = REG_ADDR_WIDTH'(w_instr[19:15]);
   assign w_rs2    = REG_ADDR_WIDTH'(w_instr[24:20]);

   // Immediate formats
   logic [DATA_WIDTH-1:0] w_imm_i;
   logic [DATA_WIDTH-1:0] w_imm_s;
   logic [DATA_WIDTH-1:0] w_imm_b;
   logic [DATA_WIDTH-1:0] w_imm_sh;

   assign w_imm_i  = DATA_WIDTH'($signed(w_instr[31:20]));
   assign w_imm_s  = DATA_WIDTH'($signed({w_instr[31:25], w_instr[11:7]}));
   assign w_imm_b  = DATA_WIDTH'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                          w_instr[11:8], 1'b0}));
   assign w_imm_sh = DATA_WIDTH'(w_instr[24:20]);

   // Decoded control
   logic [2:0]            w_alu_ctrl;
   logic                  w_alu_src;
   logic [DATA_WIDTH-1:0] w_imm;
   logic                  w_reg_write;
   logic                  w_mem_read;
   logic                  w_mem_write;
   logic [1:0]            w_branch;
   logic                  w_illegal;
   logic                  w_uses_rs2;

   assign w_uses_rs2 = (w_opcode == OP_REG) || (w_opcode == OP_STORE) ||
                       (w_opcode == OP_BRANCH);

   always_comb begin
      w_alu_ctrl  = ALU_ADD;
      w_alu_src   = 1'b0;
      w_imm       = '0;
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_branch    = BR_NONE;
      w_illegal   = 1'b0;

      case (w_opcode)
         OP_REG: begin
            w_reg_write = 1'b1;
            case ({w_funct7, w_funct3})
               {7'h00, 3'b000}: w_alu_ctrl = ALU_ADD;
               {7'h20, 3'b000}: w_alu_ctrl = ALU_SUB;
               {7'h00, 3'b001}: w_alu_ctrl = ALU_SLL;
               {7'h00, 3'b101}: w_alu_ctrl = ALU_SRL;
               {7'h20, 3'b101}: w_alu_ctrl = ALU_SRA;
               {7'h00, 3'b100}: w_alu_ctrl = ALU_XOR;
               {7'h00, 3'b110}: w_alu_ctrl = ALU_OR;
               {7'h00, 3'b111}: w_alu_ctrl = ALU_AND;
               default:         w_illegal  = 1'b1;
            endcase
         end
         OP_IMM: begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm       = w_imm_i;
            case (w_funct3)
               3'b000: w_alu_ctrl = ALU_ADD;
               3'b100: w_alu_ctrl = ALU_XOR;
               3'b110: w_alu_ctrl = ALU_OR;
               3'b111: w_alu_ctrl = ALU_AND;
               3'b001: begin
                  w_imm = w_imm_sh;
                  if (w_funct7 == 7'h00) w_alu_ctrl = ALU_SLL;
                  else                   w_illegal  = 1'b1;
               end
               3'b101: begin
                  w_imm = w_imm_sh;
                  if (w_funct7 == 7'h00)      w_alu_ctrl = ALU_SRL;
                  else if (w_funct7 == 7'h20) w_alu_ctrl = ALU_SRA;
                  else                        w_illegal  = 1'b1;
               end
               default: w_illegal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            if (w_funct3 == 3'b010) begin
               w_alu_src   = 1'b1;
               w_imm       = w_imm_i;
               w_mem_read  = 1'b1;
               w_reg_write = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_STORE: begin
            if (w_funct3 == 3'b010) begin
               w_alu_src   = 1'b1;
               w_imm       = w_imm_s;
               w_mem_write = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            w_alu_ctrl = ALU_SUB;
            w_imm      = w_imm_b;
            case (w_funct3)
               3'b000:  w_branch  = BR_BEQ;
               3'b001:  w_branch  = BR_BNE;
               3'b100:  w_branch  = BR_BLT;
               default: w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase

      // Unsupported encodings must not have side effects downstream
      if (w_illegal) begin
         w_alu_ctrl  = ALU_ADD;
         w_alu_src   = 1'b0;
         w_imm       = '0;
         w_reg_write = 1'b0;
         w_mem_read  = 1'b0;
         w_mem_write = 1'b0;
         w_branch    = BR_NONE;
      end
   end

   // Register file; x0 is never written and always reads as zero
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (id_bus.i_wb_en && (id_bus.i_wb_addr != '0)) begin
         r_regs[id_bus.i_wb_addr] <= id_bus.i_wb_data;
      end
   end

   logic [DATA_WIDTH-1:0] w_rs1_val;
   logic [DATA_WIDTH-1:0] w_rs2_val;

   always_comb begin
      w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
      w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
`ifdef ID_BYPASS_EN
      if (id_bus.i_wb_en && (id_bus.i_wb_addr != '0)) begin
         if (id_bus.i_wb_addr == w_rs1) w_rs1_val = id_bus.i_wb_data;
         if (id_bus.i_wb_addr == w_rs2) w_rs2_val = id_bus.i_wb_data;
      end
`endif
   end

   // ID/EX pipeline register
   logic                      r_valid;
   logic [DATA_WIDTH-1:0]     r_pc;
   logic [DATA_WIDTH-1:0]     r_reg1;
   logic [DATA_WIDTH-1:0]     r_reg2;
   logic [DATA_WIDTH-1:0]     r_imm;
   logic                      r_alu_src;
   logic [2:0]                r_alu_ctrl;
   logic [REG_ADDR_WIDTH-1:0] r_rd;
   logic                      r_reg_write;
   logic                      r_mem_read;
   logic                      r_mem_write;
   logic [1:0]                r_branch;
   logic                      r_illegal;

   // Load-use: the load in EX produces a value this instruction reads
   logic w_hazard;
   logic w_accept;

   assign w_hazard = r_valid && r_mem_read && (r_rd != '0) &&
                     ((r_rd == w_rs1) || (w_uses_rs2 && (r_rd == w_rs2)));
   assign id_bus.o_instr_ready = !i_rst &&
                                 (id_bus.i_flush || (!id_bus.i_stall && !w_hazard));
   assign w_accept = id_bus.i_instr_valid && !id_bus.i_flush &&
                     !id_bus.i_stall && !w_hazard;

   logic                      w_nxt_valid;
   logic [DATA_WIDTH-1:0]     w_nxt_pc;
   logic [DATA_WIDTH-1:0]     w_nxt_reg1;
   logic [DATA_WIDTH-1:0]     w_nxt_reg2;
   logic [DATA_WIDTH-1:0]     w_nxt_imm;
   logic                      w_nxt_alu_src;
   logic [2:0]                w_nxt_alu_ctrl;
   logic [REG_ADDR_WIDTH-1:0] w_nxt_rd;
   logic                      w_nxt_reg_write;
   logic                      w_nxt_mem_read;
   logic                      w_nxt_mem_write;
   logic [1:0]                w_nxt_branch;
   logic                      w_nxt_illegal;

   // Hold by default; flush, bubble or idle clear; an accepted instruction loads
   always_comb begin
      w_nxt_valid     = r_valid;
      w_nxt_pc        = r_pc;
      w_nxt_reg1      = r_reg1;
      w_nxt_reg2      = r_reg2;
      w_nxt_imm       = r_imm;
      w_nxt_alu_src   = r_alu_src;
      w_nxt_alu_ctrl  = r_alu_ctrl;
      w_nxt_rd        = r_rd;
      w_nxt_reg_write = r_reg_write;
      w_nxt_mem_read  = r_mem_read;
      w_nxt_mem_write = r_mem_write;
      w_nxt_branch    = r_branch;
      w_nxt_illegal   = r_illegal;

      if (id_bus.i_flush || !id_bus.i_stall) begin
         w_nxt_valid     = 1'b0;
         w_nxt_pc        = '0;
         w_nxt_reg1      = '0;
         w_nxt_reg2      = '0;
         w_nxt_imm       = '0;
         w_nxt_alu_src   = 1'b0;
         w_nxt_alu_ctrl  = ALU_ADD;
         w_nxt_rd        = '0;
         w_nxt_reg_write = 1'b0;
         w_nxt_mem_read  = 1'b0;
         w_nxt_mem_write = 1'b0;
         w_nxt_branch    = BR_NONE;
         w_nxt_illegal   = 1'b0;
      end

      if (w_accept) begin
         w_nxt_valid     = 1'b1;
         w_nxt_pc        = id_bus.i_PC;
         w_nxt_reg1      = w_rs1_val;
         w_nxt_reg2      = w_rs2_val;
         w_nxt_imm       = w_imm;
         w_nxt_alu_src   = w_alu_src;
         w_nxt_alu_ctrl  = w_alu_ctrl;
         w_nxt_rd        = w_reg_write ? w_rd : '0;
         w_nxt_reg_write = w_reg_write;
         w_nxt_mem_read  = w_mem_read;
         w_nxt_mem_write = w_mem_write;
         w_nxt_branch    = w_branch;
         w_nxt_illegal   = w_illegal;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_reg1      <= '0;
         r_reg2      <= '0;
         r_imm       <= '0;
         r_alu_src   <= 1'b0;
         r_alu_ctrl  <= ALU_ADD;
         r_rd        <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= BR_NONE;
         r_illegal   <= 1'b0;
      end else begin
         r_valid     <= w_nxt_valid;
         r_pc        <= w_nxt_pc;
         r_reg1      <= w_nxt_reg1;
         r_reg2      <= w_nxt_reg2;
         r_imm       <= w_nxt_imm;
         r_alu_src   <= w_nxt_alu_src;
         r_alu_ctrl  <= w_nxt_alu_ctrl;
         r_rd        <= w_nxt_rd;
         r_reg_write <= w_nxt_reg_write;
         r_mem_read  <= w_nxt_mem_read;
         r_mem_write <= w_nxt_mem_write;
         r_branch    <= w_nxt_branch;
         r_illegal   <= w_nxt_illegal;
      end
   end

   assign id_bus.o_valid      = r_valid;
   assign id_bus.o_PC         = r_pc;
   assign id_bus.o_register1  = r_reg1;
   assign id_bus.o_register2  = r_reg2;
   assign id_bus.o_constante  = r_imm;
   assign id_bus.o_ALUSrc     = r_alu_src;
   assign id_bus.o_ALUControl = r_alu_ctrl;
   assign id_bus.o_rd         = r_rd;
   assign id_bus.o_RegWrite   = r_reg_write;
   assign id_bus.o_MemRead    = r_mem_read;
   assign id_bus.o_MemWrite   = r_mem_write;
   assign id_bus.o_Branch     = r_branch;
   assign id_bus.o_illegal    = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expected values are hand-decoded
// from the RV32I encodings. Honours ID_BYPASS_EN for the same-cycle WB case.
module tb_id_stage;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   id_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

   id_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .id_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      bus.i_instr_valid = v;
      bus.i_instr       = instr;
      bus.i_PC          = pc;
   endtask

   task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
      bus.i_wb_en   = en;
      bus.i_wb_addr = addr;
      bus.i_wb_data = data;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      bus.i_stall = 1'b0;
      bus.i_flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      wb(1'b0, 5'd0, 32'h0);

      repeat (2) tick();
      check("rst_valid", 32'(bus.o_valid), 32'h0);
      check("rst_ready", 32'(bus.o_instr_ready), 32'h0);
      check("rst_pc", bus.o_PC, 32'h0);
      check("rst_regwrite", 32'(bus.o_RegWrite), 32'h0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.o_instr_ready), 32'h1);

      // addi x1,x0,5
      drive(1'b1, 32'h00500093, 32'h10);
      tick();
      check("addi_valid", 32'(bus.o_valid), 32'h1);
      check("addi_alu", 32'(bus.o_ALUControl), 32'h0);
      check("addi_src", 32'(bus.o_ALUSrc), 32'h1);
      check("addi_imm", bus.o_constante, 32'h5);
      check("addi_rd", 32'(bus.o_rd), 32'h1);
      check("addi_regwrite", 32'(bus.o_RegWrite), 32'h1);
      check("addi_pc", bus.o_PC, 32'h10);

      // idle cycles while WB fills x1=3, x2=1
      drive(1'b0, 32'h0, 32'h0);
      wb(1'b1, 5'd1, 32'd3);
      tick();
      check("idle_valid", 32'(bus.o_valid), 32'h0);
      check("idle_regwrite", 32'(bus.o_RegWrite), 32'h0);
      wb(1'b1, 5'd2, 32'd1);
      tick();
      wb(1'b0, 5'd0, 32'h0);

      // sub x3,x1,x2
      drive(1'b1, 32'h402081B3, 32'h14);
      tick();
      check("sub_r1", bus.o_register1, 32'd3);
      check("sub_r2", bus.o_register2, 32'd1);
      check("sub_alu", 32'(bus.o_ALUControl), 32'h1);
      check("sub_src", 32'(bus.o_ALUSrc), 32'h0);
      check("sub_rd", 32'(bus.o_rd), 32'd3);

      // srai x7,x1,2 : shamt zero-extended despite funct7=0x20
      drive(1'b1, 32'h4020D393, 32'h18);
      tick();
      check("srai_alu", 32'(bus.o_ALUControl), 32'h4);
      check("srai_imm", bus.o_constante, 32'h2);
      check("srai_rd", 32'(bus.o_rd), 32'd7);

      // lw x5,8(x1) followed by dependent add x6,x5,x0
      drive(1'b1, 32'h0080A283, 32'h20);
      tick();
      check("lw_memread", 32'(bus.o_MemRead), 32'h1);
      check("lw_imm", bus.o_constante, 32'h8);
      check("lw_rd", 32'(bus.o_rd), 32'd5);
      drive(1'b1, 32'h00028333, 32'h24);
      #1;
      check("hz_ready", 32'(bus.o_instr_ready), 32'h0);
      tick();
      check("hz_bubble", 32'(bus.o_valid), 32'h0);
      check("hz_ready_again", 32'(bus.o_instr_ready), 32'h1);
      tick();
      check("hz_add_valid", 32'(bus.o_valid), 32'h1);
      check("hz_add_rd", 32'(bus.o_rd), 32'd6);
      check("hz_add_pc", bus.o_PC, 32'h24);
      check("hz_add_memread", 32'(bus.o_MemRead), 32'h0);

      // beq x1,x2,-4
      drive(1'b1, 32'hFE208EE3, 32'h28);
      tick();
      check("beq_branch", 32'(bus.o_Branch), 32'h1);
      check("beq_alu", 32'(bus.o_ALUControl), 32'h1);
      check("beq_imm", bus.o_constante, 32'hFFFFFFFC);
      check("beq_regwrite", 32'(bus.o_RegWrite), 32'h0);
      check("beq_rd", 32'(bus.o_rd), 32'h0);

      // 0xFE208E63 has imm[11]=0, so it decodes to -2052
      drive(1'b1, 32'hFE208E63, 32'h2C);
      tick();
      check("beq2_imm", bus.o_constante, 32'hFFFFF7FC);

      // blt x1,x2,8
      drive(1'b1, 32'h0020C463, 32'h30);
      tick();
      check("blt_branch", 32'(bus.o_Branch), 32'h3);
      check("blt_imm", bus.o_constante, 32'h8);

      // stall 3 cycles with add x3,x1,x2 presented; WB x9 proceeds meanwhile
      drive(1'b1, 32'h002081B3, 32'h34);
      bus.i_stall = 1'b1;
      wb(1'b1, 5'd9, 32'h55);
      #1;
      check("stall_ready", 32'(bus.o_instr_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         wb(1'b0, 5'd0, 32'h0);
         check("stall_valid", 32'(bus.o_valid), 32'h1);
         check("stall_branch", 32'(bus.o_Branch), 32'h3);
         check("stall_pc", bus.o_PC, 32'h30);
      end
      bus.i_flush = 1'b1;
      #1;
      check("flush_ready", 32'(bus.o_instr_ready), 32'h1);
      tick();
      check("flush_valid", 32'(bus.o_valid), 32'h0);
      check("flush_branch", 32'(bus.o_Branch), 32'h0);
      bus.i_flush = 1'b0;
      bus.i_stall = 1'b0;

      // add x10,x9,x0 sees the write made during the stall
      drive(1'b1, 32'h00048533, 32'h38);
      tick();
      check("stallwb_r1", bus.o_register1, 32'h55);
      check("stallwb_rd", 32'(bus.o_rd), 32'd10);

      // sw x2,4(x1) and sw x2,-8(x1)
      drive(1'b1, 32'h0020A223, 32'h3C);
      tick();
      check("sw_memwrite", 32'(bus.o_MemWrite), 32'h1);
      check("sw_imm", bus.o_constante, 32'h4);
      check("sw_rd", 32'(bus.o_rd), 32'h0);
      check("sw_src", 32'(bus.o_ALUSrc), 32'h1);
      check("sw_r2", bus.o_register2, 32'd1);
      drive(1'b1, 32'hFE20AC23, 32'h40);
      tick();
      check("sw_neg_imm", bus.o_constante, 32'hFFFFFFF8);

      // illegal: all-zero word and slt
      drive(1'b1, 32'h00000000, 32'h44);
      tick();
      check("ill0_valid", 32'(bus.o_valid), 32'h1);
      check("ill0_illegal", 32'(bus.o_illegal), 32'h1);
      check("ill0_regwrite", 32'(bus.o_RegWrite), 32'h0);
      drive(1'b1, 32'h0020A1B3, 32'h48);
      tick();
      check("slt_illegal", 32'(bus.o_illegal), 32'h1);
      check("slt_rd", 32'(bus.o_rd), 32'h0);

      // same-cycle WB x4 while decoding add x3,x4,x0
      wb(1'b1, 5'd4, 32'hDEADBEEF);
      drive(1'b1, 32'h000201B3, 32'h4C);
      tick();
`ifdef ID_BYPASS_EN
      check("wb_same_cycle", bus.o_register1, 32'hDEADBEEF);
`else
      check("wb_same_cycle", bus.o_register1, 32'h0);
`endif
      check("legal_after_ill", 32'(bus.o_illegal), 32'h0);
      wb(1'b0, 5'd0, 32'h0);
      tick();
      check("wb_next_cycle", bus.o_register1, 32'hDEADBEEF);

      // write to x0 is ignored
      wb(1'b1, 5'd0, 32'h1234);
      drive(1'b1, 32'h000001B3, 32'h50);
      tick();
      check("x0_same_cycle", bus.o_register1, 32'h0);
      wb(1'b0, 5'd0, 32'h0);
      tick();
      check("x0_after", bus.o_register1, 32'h0);

      // flush without stall drops a valid input
      drive(1'b1, 32'h00500093, 32'h54);
      bus.i_flush = 1'b1;
      #1;
      check("flush2_ready", 32'(bus.o_instr_ready), 32'h1);
      tick();
      check("flush2_valid", 32'(bus.o_valid), 32'h0);
      bus.i_flush = 1'b0;

      // reset in the middle of a load-use hazard
      drive(1'b1, 32'h0080A283, 32'h58);
      tick();
      drive(1'b1, 32'h00028333, 32'h5C);
      #1;
      check("hz2_ready", 32'(bus.o_instr_ready), 32'h0);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 32'(bus.o_valid), 32'h0);
      check("rst_mid_memread", 32'(bus.o_MemRead), 32'h0);
      tick();
      rst = 1'b0;
      drive(1'b1, 32'h000081B3, 32'h60);
      tick();
      check("rst_rf_cleared", bus.o_register1, 32'h0);
      check("rst_post_valid", 32'(bus.o_valid), 32'h1);
      drive(1'b0, 32'h0, 32'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
